matmul_tile_scheduler: RTL and testbench

- Parametrised tile scheduler for the multi-MAC matrix-multiply array; computes C = A x B in BLOCK_SIZE x BLOCK_SIZE tiles.
- Walks every output tile of C and every inner-dimension step k, issuing tile addresses for A and B.
- Pulses the cores to start each step and controls accumulator clearing.
- Hands each finished C tile to writeback over a valid/ready handshake.
- Supports NUM_CORES cores working on adjacent C column tiles in parallel, and two traversal modes.

---
 rtl/matmul_tile_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for the multi-MAC matmul array: walks C tiles and k-steps, pulses cores, hands tiles to writeback.
// One LOAD cycle per k-step, then waits on systolic_finish; DRAIN holds the tile group until out_ready.
module matmul_tile_scheduler #(
  parameter int BLOCK_SIZE      = 2,
  parameter int INNER_DIMENSION = 64,
  parameter int ROW_SIZE_MAT_A  = 16,
  parameter int COL_SIZE_MAT_B  = 10,
  parameter int NUM_CORES       = 4,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_systolic_finish,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_core_start,
  output logic                  o_acc_clear,
  output logic [NUM_CORES-1:0]  o_core_mask,
  output logic [ADDR_WIDTH-1:0] o_addr_a,
  output logic [ADDR_WIDTH-1:0] o_addr_b,
  output logic                  o_out_valid,
  output logic [ADDR_WIDTH-1:0] o_out_row,
  output logic [ADDR_WIDTH-1:0] o_out_col_group,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int K_TILES    = INNER_DIMENSION / BLOCK_SIZE;
  localparam int ROW_TILES  = ROW_SIZE_MAT_A / BLOCK_SIZE;
  localparam int COL_TILES  = COL_SIZE_MAT_B / BLOCK_SIZE;
  localparam int COL_GROUPS = (COL_TILES + NUM_CORES - 1) / NUM_CORES;

  localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(K_TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(ROW_TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] CG_LAST  = ADDR_WIDTH'(COL_GROUPS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_STRIDE = ADDR_WIDTH'(K_TILES);
  localparam logic [ADDR_WIDTH-1:0] B_STRIDE = ADDR_WIDTH'(NUM_CORES * K_TILES);

  if (INNER_DIMENSION % BLOCK_SIZE != 0) begin : g_bad_inner
    $error("INNER_DIMENSION must be a multiple of BLOCK_SIZE");
  end
  if (ROW_SIZE_MAT_A % BLOCK_SIZE != 0) begin : g_bad_rows
    $error("ROW_SIZE_MAT_A must be a multiple of BLOCK_SIZE");
  end
  if (COL_SIZE_MAT_B % BLOCK_SIZE != 0) begin : g_bad_cols
    $error("COL_SIZE_MAT_B must be a multiple of BLOCK_SIZE");
  end
  // Largest addresses issued (including per-core offsets on B) must fit the address bus.
  if (longint'(ROW_TILES) * K_TILES > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr_a
    $error("addr_a range exceeds ADDR_WIDTH");
  end
  if (longint'(COL_GROUPS) * NUM_CORES * K_TILES > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr_b
    $error("addr_b range exceeds ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_mode;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_tile_row;
  logic [ADDR_WIDTH-1:0] r_col_group;
  logic [ADDR_WIDTH-1:0] r_k_idx;
  logic [ADDR_WIDTH-1:0] w_row_nxt;
  logic [ADDR_WIDTH-1:0] w_cg_nxt;
  logic [NUM_CORES-1:0]  w_mask;
  logic                  w_accept;
  logic                  w_step_done;
  logic                  w_last_k;
  logic                  w_handshake;
  logic                  w_last_group;

  assign w_accept     = (r_state == S_IDLE) && i_start;
  assign w_step_done  = (r_state == S_WAIT) && i_systolic_finish;
  assign w_last_k     = (r_k_idx == K_LAST);
  assign w_handshake  = (r_state == S_DRAIN) && i_out_ready;
  assign w_last_group = (r_tile_row == ROW_LAST) && (r_col_group == CG_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:  if (i_systolic_finish) w_next = w_last_k ? S_DRAIN : S_LOAD;
      S_DRAIN: if (i_out_ready) w_next = w_last_group ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Mode 0 sweeps column groups within a row; mode 1 sweeps rows within a column group.
  always_comb begin
    w_row_nxt = r_tile_row;
    w_cg_nxt  = r_col_group;
    if (!r_mode) begin
      if (r_col_group == CG_LAST) begin
        w_cg_nxt  = '0;
        w_row_nxt = (r_tile_row == ROW_LAST) ? '0 : r_tile_row + 1'b1;
      end else begin
        w_cg_nxt = r_col_group + 1'b1;
      end
    end else begin
      if (r_tile_row == ROW_LAST) begin
        w_row_nxt = '0;
        w_cg_nxt  = (r_col_group == CG_LAST) ? '0 : r_col_group + 1'b1;
      end else begin
        w_row_nxt = r_tile_row + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode      <= 1'b0;
      r_err       <= 1'b0;
      r_tile_row  <= '0;
      r_col_group <= '0;
      r_k_idx     <= '0;
    end else if (w_accept) begin
      // A finish arriving together with start is still spurious.
      r_mode      <= i_mode;
      r_err       <= i_systolic_finish;
      r_tile_row  <= '0;
      r_col_group <= '0;
      r_k_idx     <= '0;
    end else begin
      if (i_systolic_finish && (r_state != S_WAIT)) begin
        r_err <= 1'b1;
      end
      if (w_step_done && !w_last_k) begin
        r_k_idx <= r_k_idx + 1'b1;
      end
      if (w_handshake) begin
        r_k_idx     <= '0;
        r_tile_row  <= w_row_nxt;
        r_col_group <= w_cg_nxt;
      end
    end
  end

  // Cores past the last real column tile are disabled in the partial group.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_mask[i] = (32'(r_col_group) * 32'(NUM_CORES) + 32'(i)) < 32'(COL_TILES);
    end
  end

  always_comb begin
    o_busy          = 1'b0;
    o_core_start    = 1'b0;
    o_acc_clear     = 1'b0;
    o_core_mask     = '0;
    o_addr_a        = '0;
    o_addr_b        = '0;
    o_out_valid     = 1'b0;
    o_out_row       = '0;
    o_out_col_group = '0;
    o_done          = 1'b0;
    o_err           = r_err;
    case (r_state)
      S_LOAD, S_WAIT: begin
        o_busy       = 1'b1;
        o_core_start = (r_state == S_LOAD);
        o_acc_clear  = (r_state == S_LOAD) && (r_k_idx == '0);
        o_core_mask  = w_mask;
        o_addr_a     = r_tile_row * A_STRIDE + r_k_idx;
        o_addr_b     = r_col_group * B_STRIDE + r_k_idx;
      end
      S_DRAIN: begin
        o_busy          = 1'b1;
        o_core_mask     = w_mask;
        o_out_valid     = 1'b1;
        o_out_row       = r_tile_row;
        o_out_col_group = r_col_group;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler with a 2x3-tile C, 4 k-steps and 2 cores.
module tb_matmul_tile_scheduler;
  localparam int AW = 16;
  localparam int NC = 2;

  // Hand-derived group order and masks: index 0 = mode 0, index 1 = mode 1.
  localparam int ROW_M0 [4] = '{0, 0, 1, 1};
  localparam int CG_M0  [4] = '{0, 1, 0, 1};
  localparam int MSK_M0 [4] = '{3, 1, 3, 1};
  localparam int ROW_M1 [4] = '{0, 1, 0, 1};
  localparam int CG_M1  [4] = '{0, 0, 1, 1};
  localparam int MSK_M1 [4] = '{3, 3, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, fin, ready;
  logic busy, core_start, acc_clear, out_valid, done, err;
  logic [NC-1:0] core_mask;
  logic [AW-1:0] addr_a, addr_b, out_row, out_cg;

  matmul_tile_scheduler #(
    .BLOCK_SIZE(2), .INNER_DIMENSION(8), .ROW_SIZE_MAT_A(4),
    .COL_SIZE_MAT_B(6), .NUM_CORES(NC), .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_systolic_finish(fin), .i_out_ready(ready),
    .o_busy(busy), .o_core_start(core_start), .o_acc_clear(acc_clear),
    .o_core_mask(core_mask), .o_addr_a(addr_a), .o_addr_b(addr_b),
    .o_out_valid(out_valid), .o_out_row(out_row), .o_out_col_group(out_cg),
    .o_done(done), .o_err(err)
  );

  int checks = 0;
  int errors = 0;

  int            n_cs, n_grp, n_done, n_st;
  int            cs_cyc  [32];
  logic [AW-1:0] cs_a    [32];
  logic [AW-1:0] cs_b    [32];
  logic          cs_clr  [32];
  logic [NC-1:0] cs_mask [32];
  logic [AW-1:0] g_row   [8];
  logic [AW-1:0] g_cg    [8];
  logic [NC-1:0] g_mask  [8];
  logic          st_vld  [8];
  logic          st_cs   [8];
  logic [AW-1:0] st_row  [8];
  logic [AW-1:0] st_cg   [8];
  logic          load_after, busy_after, timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full run: answers each core_start with finish 3 cycles later and logs what it sees.
  task automatic run(input logic m, input int stall, input logic poke, input int abort_at);
    int cnt = 0;
    int stall_left = stall;
    int done_age = 0;
    logic chk_load = 1'b0;
    n_cs = 0; n_grp = 0; n_done = 0; n_st = 0;
    timed_out = 1'b0; load_after = 1'b0; busy_after = 1'b1;
    mode = m; start = 1'b1; fin = 1'b0; ready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      start = 1'b0;
      mode  = 1'b0;
      fin   = 1'b0;
      ready = 1'b1;
      if (chk_load) begin
        load_after = core_start;
        chk_load   = 1'b0;
      end
      if (n_done > 0) begin
        done_age++;
        if (done_age == 1) busy_after = busy;
        if (done_age == 2) return;
      end
      if (done) n_done++;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) fin = 1'b1;
      end
      if (core_start && n_cs < 32) begin
        cs_cyc[n_cs] = cyc; cs_a[n_cs] = addr_a; cs_b[n_cs] = addr_b;
        cs_clr[n_cs] = acc_clear; cs_mask[n_cs] = core_mask;
        n_cs++;
        cnt = 3;
      end
      if (abort_at >= 0 && n_cs == abort_at + 1 && !core_start) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      if (out_valid) begin
        if (stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
          if (n_st < 8) begin
            st_vld[n_st] = out_valid; st_cs[n_st] = core_start;
            st_row[n_st] = out_row;   st_cg[n_st] = out_cg;
            n_st++;
          end
        end else if (n_grp < 8) begin
          if (stall > 0 && n_grp == 0) chk_load = 1'b1;
          g_row[n_grp] = out_row; g_cg[n_grp] = out_cg; g_mask[n_grp] = core_mask;
          n_grp++;
        end
      end
      start = poke && busy;
    end
    timed_out = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; fin = 1'b1; mode = 1'b0; ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, core_start, acc_clear, core_mask, addr_a, addr_b, out_valid, out_row, out_cg, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b cs=%0b clr=%0b mask=%b a=%0d b=%0d vld=%0b row=%0d cg=%0d done=%0b err=%0b, want all 0",
               busy, core_start, acc_clear, core_mask, addr_a, addr_b, out_valid, out_row, out_cg, done, err);
    end
    rst = 1'b0; start = 1'b0; fin = 1'b0;
    tick();
    checks++;
    if ({busy, err} !== 2'b00) begin errors++; $display("FAIL reset_idle: got busy=%0b err=%0b want 0 0", busy, err); end
  endtask

  task automatic test_mode0();
    run(1'b0, 0, 1'b0, -1);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL m0_timeout: run did not complete within budget"); end
    checks++;
    if (n_cs !== 16) begin errors++; $display("FAIL m0_core_starts: got %0d want 16", n_cs); end
    for (int j = 0; j < 16 && j < n_cs; j++) begin
      int g, k;
      g = j / 4; k = j % 4;
      checks++;
      if (cs_clr[j] !== (k == 0) || cs_a[j] !== AW'(ROW_M0[g] * 4 + k) || cs_b[j] !== AW'(CG_M0[g] * 8 + k)
          || cs_mask[j] !== NC'(MSK_M0[g])) begin
        errors++;
        $display("FAIL m0_step%0d: got clr=%0b a=%0d b=%0d mask=%b want clr=%0b a=%0d b=%0d mask=%b", j,
                 cs_clr[j], cs_a[j], cs_b[j], cs_mask[j], (k == 0), ROW_M0[g] * 4 + k, CG_M0[g] * 8 + k, NC'(MSK_M0[g]));
      end
      if (k != 0) begin
        checks++;
        if (cs_cyc[j] - cs_cyc[j-1] !== 4) begin
          errors++; $display("FAIL m0_kstep_spacing%0d: got %0d cycles want 4", j, cs_cyc[j] - cs_cyc[j-1]);
        end
      end
    end
    checks++;
    if (n_grp !== 4) begin errors++; $display("FAIL m0_groups: got %0d want 4", n_grp); end
    for (int g = 0; g < 4 && g < n_grp; g++) begin
      checks++;
      if (g_row[g] !== AW'(ROW_M0[g]) || g_cg[g] !== AW'(CG_M0[g]) || g_mask[g] !== NC'(MSK_M0[g])) begin
        errors++;
        $display("FAIL m0_group%0d: got (%0d,%0d) mask=%b want (%0d,%0d) mask=%b", g,
                 g_row[g], g_cg[g], g_mask[g], ROW_M0[g], CG_M0[g], NC'(MSK_M0[g]));
      end
    end
    checks++;
    if (n_done !== 1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL m0_done: got done_pulses=%0d busy_after=%0b want 1 0", n_done, busy_after);
    end
  endtask

  task automatic test_mode1();
    run(1'b1, 0, 1'b0, -1);
    checks++;
    if (timed_out !== 1'b0 || n_cs !== 16) begin
      errors++; $display("FAIL m1_run: got timeout=%0b core_starts=%0d want 0 16", timed_out, n_cs);
    end
    for (int j = 0; j < 16 && j < n_cs; j++) begin
      int g, k;
      g = j / 4; k = j % 4;
      checks++;
      if (cs_clr[j] !== (k == 0) || cs_a[j] !== AW'(ROW_M1[g] * 4 + k) || cs_b[j] !== AW'(CG_M1[g] * 8 + k)) begin
        errors++;
        $display("FAIL m1_step%0d: got clr=%0b a=%0d b=%0d want clr=%0b a=%0d b=%0d", j,
                 cs_clr[j], cs_a[j], cs_b[j], (k == 0), ROW_M1[g] * 4 + k, CG_M1[g] * 8 + k);
      end
    end
    checks++;
    if (n_grp !== 4) begin errors++; $display("FAIL m1_groups: got %0d want 4", n_grp); end
    for (int g = 0; g < 4 && g < n_grp; g++) begin
      checks++;
      if (g_row[g] !== AW'(ROW_M1[g]) || g_cg[g] !== AW'(CG_M1[g]) || g_mask[g] !== NC'(MSK_M1[g])) begin
        errors++;
        $display("FAIL m1_group%0d: got (%0d,%0d) mask=%b want (%0d,%0d) mask=%b", g,
                 g_row[g], g_cg[g], g_mask[g], ROW_M1[g], CG_M1[g], NC'(MSK_M1[g]));
      end
    end
    checks++;
    if (n_done !== 1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL m1_done: got done_pulses=%0d busy_after=%0b want 1 0", n_done, busy_after);
    end
  endtask

  task automatic test_stall();
    run(1'b0, 5, 1'b0, -1);
    checks++;
    if (n_st !== 5) begin errors++; $display("FAIL stall_cycles: got %0d stalled cycles want 5", n_st); end
    for (int s = 0; s < n_st && s < 5; s++) begin
      checks++;
      if (st_vld[s] !== 1'b1 || st_cs[s] !== 1'b0 || st_row[s] !== '0 || st_cg[s] !== '0) begin
        errors++;
        $display("FAIL stall%0d: got vld=%0b cs=%0b row=%0d cg=%0d want 1 0 0 0", s, st_vld[s], st_cs[s], st_row[s], st_cg[s]);
      end
    end
    checks++;
    if (load_after !== 1'b1) begin errors++; $display("FAIL stall_load_after_ready: got core_start=%0b want 1", load_after); end
    checks++;
    if (timed_out !== 1'b0 || n_done !== 1 || n_grp !== 4) begin
      errors++; $display("FAIL stall_complete: got timeout=%0b done=%0d groups=%0d want 0 1 4", timed_out, n_done, n_grp);
    end
  endtask

  task automatic test_spurious_finish();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_idle: got err=%0b busy=%0b want 1 0", err, busy); end
    tick();
    tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", err); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || core_start !== 1'b1) begin
      errors++; $display("FAIL err_clear_on_start: got err=%0b core_start=%0b want 0 1", err, core_start);
    end
    fin = 1'b1;
    tick();
    fin = 1'b0;
    checks++;
    if (err !== 1'b1 || core_start !== 1'b0 || addr_a !== '0 || addr_b !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_load: got err=%0b cs=%0b a=%0d b=%0d vld=%0b want 1 0 0 0 0", err, core_start, addr_a, addr_b, out_valid);
    end
    tick();
    checks++;
    if (core_start !== 1'b0 || addr_a !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL err_no_advance: got cs=%0b a=%0d busy=%0b want 0 0 1", core_start, addr_a, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; fin = 1'b1;
    tick();
    start = 1'b0; fin = 1'b0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b1 || core_start !== 1'b1) begin
      errors++; $display("FAIL start_and_finish: got busy=%0b err=%0b cs=%0b want 1 1 1", busy, err, core_start);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    run(1'b0, 0, 1'b0, 6);
    checks++;
    if (n_cs !== 7 || cs_a[6] !== AW'(2) || cs_b[6] !== AW'(10)) begin
      errors++; $display("FAIL abort_point: got steps=%0d a=%0d b=%0d want 7 2 10", n_cs, cs_a[6], cs_b[6]);
    end
    checks++;
    if ({busy, core_start, acc_clear, core_mask, addr_a, addr_b, out_valid, out_row, out_cg, done, err} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%0b cs=%0b mask=%b a=%0d b=%0d vld=%0b err=%0b want all 0",
               busy, core_start, core_mask, addr_a, addr_b, out_valid, err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (core_start !== 1'b1 || acc_clear !== 1'b1 || addr_a !== '0 || addr_b !== '0 || core_mask !== 2'b11) begin
      errors++;
      $display("FAIL restart: got cs=%0b clr=%0b a=%0d b=%0d mask=%b want 1 1 0 0 11", core_start, acc_clear, addr_a, addr_b, core_mask);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back_start();
    run(1'b0, 0, 1'b1, -1);
    checks++;
    if (timed_out !== 1'b0 || n_cs !== 16 || n_grp !== 4) begin
      errors++; $display("FAIL poke_run: got timeout=%0b steps=%0d groups=%0d want 0 16 4", timed_out, n_cs, n_grp);
    end
    for (int j = 0; j < 16 && j < n_cs; j++) begin
      int g, k;
      g = j / 4; k = j % 4;
      checks++;
      if (cs_clr[j] !== (k == 0) || cs_a[j] !== AW'(ROW_M0[g] * 4 + k) || cs_b[j] !== AW'(CG_M0[g] * 8 + k)) begin
        errors++;
        $display("FAIL poke_step%0d: got clr=%0b a=%0d b=%0d want clr=%0b a=%0d b=%0d", j,
                 cs_clr[j], cs_a[j], cs_b[j], (k == 0), ROW_M0[g] * 4 + k, CG_M0[g] * 8 + k);
      end
    end
    for (int g = 0; g < 4 && g < n_grp; g++) begin
      checks++;
      if (g_row[g] !== AW'(ROW_M0[g]) || g_cg[g] !== AW'(CG_M0[g])) begin
        errors++; $display("FAIL poke_group%0d: got (%0d,%0d) want (%0d,%0d)", g, g_row[g], g_cg[g], ROW_M0[g], CG_M0[g]);
      end
    end
    checks++;
    if (n_done !== 1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL poke_done: got done_pulses=%0d busy_after=%0b want 1 0", n_done, busy_after);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; fin = 1'b0; ready = 1'b1;
    test_reset();
    test_mode0();
    test_mode1();
    test_stall();
    test_spurious_finish();
    test_reset_mid_run();
    test_back_to_back_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
